sqrt_request_scheduler: RTL and testbench
=========================================

// Module: sqrt_request_scheduler
// PURPOSE
// Front/back-end wrapper for the iterative non-restoring square root core.
// - Buffers tagged sqrt requests from the issue stage in a small FIFO.
// - Launches one operation at a time on the core: 1-cycle start pulse, only when the core is idle.
// - Captures the core's 1-cycle result pulse into a held output slot, drained via valid/ready toward writeback.
// PARAMETERS
// DATA_WIDTH  32  radicand width; even, power of 2
// TAG_WIDTH   4   request tag (destination id), returned with the result
// DEPTH       4   request FIFO entries; power of 2, >=2
// PORTS
// clk_i          in   1                 clock
// rst_n_i        in   1                 reset, asynchronous, active-low
// req_valid_i    in   1                 request valid
// req_ready_o    out  1                 request accepted when valid&ready
// req_radicand_i in   DATA_WIDTH        unsigned radicand
// req_tag_i      in   TAG_WIDTH         request tag
// sqrt_start_o   out  1                 start pulse to core data_valid_i
// sqrt_radicand_o out DATA_WIDTH        operand to core, stable while busy
// sqrt_idle_i    in   1                 core idle_o
// sqrt_done_i    in   1                 core data_valid_o (1-cycle pulse)
// sqrt_root_i    in   DATA_WIDTH/2      core root_o
// sqrt_rem_i     in   DATA_WIDTH/2+1    core remainder_o
// res_valid_o    out  1                 result held valid
// res_ready_i    in   1                 consumer accepts result
// res_root_o     out  DATA_WIDTH/2      captured root
// res_rem_o      out  DATA_WIDTH/2+1    captured remainder
// res_tag_o      out  TAG_WIDTH         tag of captured result
// busy_o         out  1                 FIFO non-empty or operation in flight or result held
// err_o          out  1                 sticky: sqrt_done_i seen outside WAIT
// BEHAVIOUR
// - Reset values: all outputs 0. FIFO empty (req_ready_o=1 from the first cycle after reset). FSM in IDLE.
// - Reset mid-operation: drops all queued, in-flight and held data.
//   The core shares rst_n_i, so no stale completion is expected.
// - FIFO:
//   - req_ready_o = !full, registered-state only; no combinational path from res_ready_i.
//   - Push and pop in the same cycle are legal when not full.
//   - When full, a push is refused even if a pop occurs that cycle.
//   - Pointers carry 1 extra wrap bit; full/empty are decided by pointer compare.
// - FSM (IDLE, ISSUE, WAIT, HOLD):
//   - IDLE -> ISSUE when FIFO non-empty & sqrt_idle_i & !res_valid_o.
//     The head entry is popped into the operand/tag registers.
//   - ISSUE: sqrt_start_o=1 for exactly 1 cycle; -> WAIT.
//   - WAIT: sqrt_radicand_o held constant. On sqrt_done_i, capture root/rem/tag, set res_valid_o, -> HOLD.
//   - HOLD: res_valid_o=1; data stable until res_ready_i.
//     - Handshake in HOLD -> IDLE, res_valid_o cleared next cycle.
//     - If FIFO non-empty and sqrt_idle_i at that point, go directly HOLD -> ISSUE; that entry is popped in the same cycle.
// - Exactly one operation in flight. Back-to-back throughput = core latency + 2 cycles: ISSUE, capture.
// - A request pushed into an empty FIFO reaches sqrt_start_o 2 cycles later at the earliest: push, IDLE->ISSUE.
// - sqrt_done_i outside WAIT: ignored, err_o set until reset.
// - A tag is never altered; results return in request order.
// - Widths:
//   - root is DATA_WIDTH/2 and rem is DATA_WIDTH/2+1 bits, unsigned, copied unchanged.
//   - No arithmetic is done in this block.
// - busy_o = !fifo_empty | state!=IDLE | res_valid_o.
// TESTING
// 1. Single request, radicand=144, tag=3, res_ready_i=1 -> res root=12, rem=0, tag=3.
//    sqrt_start_o pulses exactly once.
// 2. radicand=32'hFFFFFFFF -> root=16'hFFFF, rem=17'd131070.
//    radicand=0 -> root=0, rem=0.
//    radicand=10 -> root=3, rem=1.
// 3. Push DEPTH+1 requests back-to-back with res_ready_i=0:
//    - the 1st issues; DEPTH more fill the FIFO, then req_ready_o=0;
//    - results emerge in tag order once ready=1.
// 4. Hold res_ready_i=0 for 50 cycles in HOLD -> outputs stable, no new sqrt_start_o.
//    Then release -> next start is issued in the same cycle as the handshake.
// 5. Assert rst_n_i low during WAIT:
//    - outputs are 0 immediately (async);
//    - after release, FIFO is empty, req_ready_o=1, and no result is produced.
// 6. Inject a sqrt_done_i pulse in IDLE -> err_o=1 and stays set; result slot unchanged.

Source files
------------

// File: rtl/sqrt_request_scheduler.sv
// Request scheduler wrapped around an iterative square-root core.
// Tagged requests queue in a small FIFO. One operation at a time is launched on the
// core with a single-cycle start pulse. The core's single-cycle result is held in an
// output slot until the writeback consumer accepts it. Tags and results pass through
// unchanged, and results leave in request order.
module sqrt_request_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [DATA_WIDTH-1:0]   req_radicand_i,
    input  logic [TAG_WIDTH-1:0]    req_tag_i,
    output logic                    sqrt_start_o,
    output logic [DATA_WIDTH-1:0]   sqrt_radicand_o,
    input  logic                    sqrt_idle_i,
    input  logic                    sqrt_done_i,
    input  logic [DATA_WIDTH/2-1:0] sqrt_root_i,
    input  logic [DATA_WIDTH/2:0]   sqrt_rem_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [DATA_WIDTH/2-1:0] res_root_o,
    output logic [DATA_WIDTH/2:0]   res_rem_o,
    output logic [TAG_WIDTH-1:0]    res_tag_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_WIDTH + TAG_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_HOLD} state_t;

    // FIFO storage and pointers; the extra MSB on each pointer tells full from empty
    logic [EW-1:0]         fifo_mem [DEPTH];
    logic [AW:0]           wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]           wr_ptr_next, rd_ptr_next;
    logic                  fifo_empty, fifo_full, full_next;
    logic                  push, pop;
    logic                  req_ready_reg;
    logic [EW-1:0]         fifo_head;

    // Control and datapath registers
    state_t                  state_reg;
    logic                    start_reg;
    logic [DATA_WIDTH-1:0]   operand_reg;
    logic [TAG_WIDTH-1:0]    tag_reg;
    logic                    res_valid_reg;
    logic [DATA_WIDTH/2-1:0] res_root_reg;
    logic [DATA_WIDTH/2:0]   res_rem_reg;
    logic [TAG_WIDTH-1:0]    res_tag_reg;
    logic                    err_reg;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr_reg[AW-1:0]];

    // Ready comes from a register, so a push is refused while full even if a pop happens
    assign push = req_valid_i & req_ready_reg;

    // Pop whenever the FSM launches: from IDLE, or straight out of HOLD on the handshake
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty && sqrt_idle_i) begin
            if (state_reg == ST_IDLE && !res_valid_reg)
                pop = 1'b1;
            else if (state_reg == ST_HOLD && res_ready_i)
                pop = 1'b1;
        end
    end

    // Next pointers, and the full flag they produce, feed the registered ready
    always_comb begin
        wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push};
        rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
        full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                      (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    end

    // FIFO pointer and ready state; ready stays low while in reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            req_ready_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            req_ready_reg <= !full_next;
        end
    end

    // FIFO storage write; the contents need no reset because the pointers qualify them
    always_ff @(posedge clk_i) begin
        if (push)
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {req_tag_i, req_radicand_i};
    end

    // Launch / wait / hold sequencer with registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= ST_IDLE;
            start_reg     <= 1'b0;
            operand_reg   <= '0;
            tag_reg       <= '0;
            res_valid_reg <= 1'b0;
            res_root_reg  <= '0;
            res_rem_reg   <= '0;
            res_tag_reg   <= '0;
            err_reg       <= 1'b0;
        end else begin
            start_reg <= 1'b0;
            // A completion pulse outside WAIT is dropped and only flagged
            if (sqrt_done_i && state_reg != ST_WAIT)
                err_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        operand_reg <= fifo_head[DATA_WIDTH-1:0];
                        tag_reg     <= fifo_head[EW-1:DATA_WIDTH];
                        start_reg   <= 1'b1;
                        state_reg   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sqrt_done_i) begin
                        res_root_reg  <= sqrt_root_i;
                        res_rem_reg   <= sqrt_rem_i;
                        res_tag_reg   <= tag_reg;
                        res_valid_reg <= 1'b1;
                        state_reg     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (res_ready_i) begin
                        res_valid_reg <= 1'b0;
                        if (pop) begin
                            operand_reg <= fifo_head[DATA_WIDTH-1:0];
                            tag_reg     <= fifo_head[EW-1:DATA_WIDTH];
                            start_reg   <= 1'b1;
                            state_reg   <= ST_ISSUE;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o     = req_ready_reg;
    assign sqrt_start_o    = start_reg;
    assign sqrt_radicand_o = operand_reg;
    assign res_valid_o     = res_valid_reg;
    assign res_root_o      = res_root_reg;
    assign res_rem_o       = res_rem_reg;
    assign res_tag_o       = res_tag_reg;
    assign err_o           = err_reg;
    assign busy_o          = !fifo_empty || (state_reg != ST_IDLE) || res_valid_reg;

endmodule

// File: tb/tb_sqrt_request_scheduler.sv
// Bench for sqrt_request_scheduler. A behavioural core model answers start pulses
// after a random latency. The main sequence runs directed steps and a random phase.
// Every result is checked against a request queue, with the root and remainder
// computed by plain arithmetic.
`timescale 1ns/1ps
module tb_sqrt_request_scheduler;

    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 4;

    logic            clk;
    logic            rst_n_i;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [DW-1:0]   req_radicand_i;
    logic [TW-1:0]   req_tag_i;
    logic            sqrt_start_o;
    logic [DW-1:0]   sqrt_radicand_o;
    logic            sqrt_idle_i;
    logic            sqrt_done_i;
    logic [DW/2-1:0] sqrt_root_i;
    logic [DW/2:0]   sqrt_rem_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [DW/2-1:0] res_root_o;
    logic [DW/2:0]   res_rem_o;
    logic [TW-1:0]   res_tag_o;
    logic            busy_o;
    logic            err_o;

    sqrt_request_scheduler #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_radicand_i(req_radicand_i), .req_tag_i(req_tag_i),
        .sqrt_start_o(sqrt_start_o), .sqrt_radicand_o(sqrt_radicand_o),
        .sqrt_idle_i(sqrt_idle_i), .sqrt_done_i(sqrt_done_i),
        .sqrt_root_i(sqrt_root_i), .sqrt_rem_i(sqrt_rem_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_root_o(res_root_o), .res_rem_o(res_rem_o), .res_tag_o(res_tag_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int starts   = 0;
    int results  = 0;
    int inject_cnt = 0;

    // Reference model: accepted requests in order
    logic [63:0] exp_rad [$];
    logic [TW-1:0] exp_tag [$];

    function automatic logic [63:0] isqrt(input logic [63:0] x);
        logic [63:0] r;
        real rx;
        rx = x;
        r = 64'($rtoi($floor($sqrt(rx))));
        while (r * r > x) r = r - 1;
        while ((r + 1) * (r + 1) <= x) r = r + 1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_result();
        logic [63:0] rad, r;
        logic [TW-1:0] tg;
        if (exp_rad.size() == 0) begin
            chk("spurious_result", 64'(res_valid_o), 64'd0);
        end else begin
            rad = exp_rad.pop_front();
            tg  = exp_tag.pop_front();
            r   = isqrt(rad);
            chk("res_root", 64'(res_root_o), r);
            chk("res_rem", 64'(res_rem_o), rad - r * r);
            chk("res_tag", 64'(res_tag_o), 64'(tg));
            results++;
            $display("result tag=%0d radicand=%08h root=%04h rem=%05h", res_tag_o, rad, res_root_o, res_rem_o);
        end
    endtask

    // One clock cycle: observe at the falling edge, then drive inputs for the next rising edge
    task automatic tick(input logic v, input logic [DW-1:0] rad, input logic [TW-1:0] tg, input logic rr);
        @(negedge clk);
        if (sqrt_start_o === 1'b1) starts++;
        req_valid_i    = v;
        req_radicand_i = rad;
        req_tag_i      = tg;
        res_ready_i    = rr;
        if (v && req_ready_o === 1'b1) begin
            exp_rad.push_back(64'(rad));
            exp_tag.push_back(tg);
        end
        if (rr && res_valid_o === 1'b1) check_result();
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while (k < max_cycles && (exp_rad.size() != 0 || busy_o !== 1'b0)) begin
            tick(1'b0, '0, '0, 1'b1);
            k++;
        end
        chk("drain_busy", 64'(busy_o), 64'd0);
        chk("drain_pending", 64'(exp_rad.size()), 64'd0);
    endtask

    task automatic wait_hold(input int max_cycles);
        int k;
        k = 0;
        while (k < max_cycles && res_valid_o !== 1'b1) begin
            tick(1'b0, '0, '0, 1'b0);
            k++;
        end
        chk("hold_reached", 64'(res_valid_o), 64'd1);
    endtask

    // Behavioural square-root core: random latency, single-cycle done pulse
    initial begin : core_model
        int cnt;
        logic cbusy;
        int inj_seen;
        logic [63:0] rr;
        sqrt_idle_i = 1'b1;
        sqrt_done_i = 1'b0;
        sqrt_root_i = '0;
        sqrt_rem_i  = '0;
        cnt = 0;
        cbusy = 1'b0;
        inj_seen = 0;
        forever begin
            @(negedge clk);
            sqrt_done_i = 1'b0;
            if (rst_n_i !== 1'b1) begin
                cbusy = 1'b0;
                sqrt_idle_i = 1'b1;
                cnt = 0;
                inj_seen = inject_cnt;
            end else if (inject_cnt != inj_seen) begin
                inj_seen++;
                sqrt_done_i = 1'b1;
                sqrt_root_i = 16'h5A5A;
                sqrt_rem_i  = 17'h1A5A5;
            end else if (cbusy) begin
                cnt--;
                if (cnt == 0) begin
                    // Uses the operand seen at completion, so it must stay stable while busy
                    rr = isqrt(64'(sqrt_radicand_o));
                    sqrt_root_i = rr[DW/2-1:0];
                    sqrt_rem_i  = 17'(64'(sqrt_radicand_o) - rr * rr);
                    sqrt_done_i = 1'b1;
                    sqrt_idle_i = 1'b1;
                    cbusy = 1'b0;
                end
            end else if (sqrt_start_o === 1'b1) begin
                cbusy = 1'b1;
                sqrt_idle_i = 1'b0;
                cnt = $urandom_range(3, 12);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int s0, r0, k;
        logic stable;
        logic [DW/2-1:0] snap_root;
        logic [DW/2:0] snap_rem;
        logic [TW-1:0] snap_tag;
        logic [DW-1:0] rad;
        int sel;

        rst_n_i = 1'b0;
        req_valid_i = 1'b0;
        req_radicand_i = '0;
        req_tag_i = '0;
        res_ready_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_res_valid", 64'(res_valid_o), 64'd0);
        chk("rst_start", 64'(sqrt_start_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        rst_n_i = 1'b1;
        tick(1'b0, '0, '0, 1'b0);
        chk("post_rst_ready", 64'(req_ready_o), 64'd1);

        // 1: single request, earliest launch is two cycles after the push
        s0 = starts; r0 = results;
        tick(1'b1, 32'd144, 4'd3, 1'b1);
        tick(1'b0, '0, '0, 1'b1);
        chk("t1_no_start_yet", 64'(sqrt_start_o), 64'd0);
        tick(1'b0, '0, '0, 1'b1);
        chk("t1_start_latency", 64'(sqrt_start_o), 64'd1);
        drain(100);
        chk("t1_start_count", 64'(starts - s0), 64'd1);
        chk("t1_result_count", 64'(results - r0), 64'd1);

        // 2: boundary radicands
        r0 = results;
        tick(1'b1, 32'hFFFFFFFF, 4'd1, 1'b1);
        tick(1'b1, 32'd0, 4'd2, 1'b1);
        tick(1'b1, 32'd10, 4'd3, 1'b1);
        drain(200);
        chk("t2_result_count", 64'(results - r0), 64'd3);

        // 3: DEPTH+1 back-to-back pushes with the consumer stalled
        r0 = results;
        for (int i = 0; i < DEPTH + 1; i++) tick(1'b1, $urandom, 4'(i), 1'b0);
        tick(1'b1, $urandom, 4'd5, 1'b0);
        chk("t3_full_ready", 64'(req_ready_o), 64'd0);
        chk("t3_accepted", 64'(exp_rad.size()), 64'(DEPTH + 1));
        tick(1'b0, '0, '0, 1'b0);
        wait_hold(100);
        chk("t3_still_full", 64'(req_ready_o), 64'd0);
        drain(400);
        chk("t3_result_count", 64'(results - r0), 64'(DEPTH + 1));

        // 4: long stall in HOLD, then the next launch follows the handshake directly
        tick(1'b1, $urandom, 4'd6, 1'b0);
        tick(1'b1, $urandom, 4'd7, 1'b0);
        wait_hold(100);
        snap_root = res_root_o; snap_rem = res_rem_o; snap_tag = res_tag_o;
        s0 = starts;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1'b0, '0, '0, 1'b0);
            if (res_valid_o !== 1'b1 || res_root_o !== snap_root ||
                res_rem_o !== snap_rem || res_tag_o !== snap_tag) stable = 1'b0;
        end
        chk("t4_stable", 64'(stable), 64'd1);
        chk("t4_no_start", 64'(starts - s0), 64'd0);
        tick(1'b0, '0, '0, 1'b1);
        tick(1'b0, '0, '0, 1'b0);
        chk("t4_start_after_hs", 64'(sqrt_start_o), 64'd1);
        chk("t4_valid_cleared", 64'(res_valid_o), 64'd0);
        drain(100);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            rad = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFFFFFF : $urandom;
            tick($urandom_range(0, 1) == 1, rad, 4'(i), $urandom_range(0, 3) != 0);
        end
        drain(600);
        chk("rand_err_clear", 64'(err_o), 64'd0);

        // 5: reset while the core is busy
        tick(1'b1, $urandom, 4'd9, 1'b1);
        k = 0;
        while (k < 20 && sqrt_idle_i !== 1'b0) begin
            tick(1'b0, '0, '0, 1'b1);
            k++;
        end
        tick(1'b0, '0, '0, 1'b1);
        chk("t5_core_busy", 64'(sqrt_idle_i), 64'd0);
        chk("t5_busy_before", 64'(busy_o), 64'd1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("t5_async_busy", 64'(busy_o), 64'd0);
        chk("t5_async_ready", 64'(req_ready_o), 64'd0);
        chk("t5_async_radicand", 64'(sqrt_radicand_o), 64'd0);
        chk("t5_async_valid", 64'(res_valid_o), 64'd0);
        chk("t5_async_start", 64'(sqrt_start_o), 64'd0);
        exp_rad.delete();
        exp_tag.delete();
        repeat (3) @(negedge clk);
        rst_n_i = 1'b1;
        s0 = starts; r0 = results;
        repeat (40) tick(1'b0, '0, '0, 1'b1);
        chk("t5_ready_after", 64'(req_ready_o), 64'd1);
        chk("t5_idle_after", 64'(busy_o), 64'd0);
        chk("t5_no_result", 64'(results - r0), 64'd0);
        chk("t5_no_start", 64'(starts - s0), 64'd0);

        // 6: stray completion pulse while idle
        inject_cnt++;
        tick(1'b0, '0, '0, 1'b0);
        tick(1'b0, '0, '0, 1'b0);
        chk("t6_err_set", 64'(err_o), 64'd1);
        chk("t6_no_valid", 64'(res_valid_o), 64'd0);
        chk("t6_root_unchanged", 64'(res_root_o), 64'd0);
        chk("t6_tag_unchanged", 64'(res_tag_o), 64'd0);
        repeat (10) tick(1'b0, '0, '0, 1'b0);
        chk("t6_err_sticky", 64'(err_o), 64'd1);
        tick(1'b1, 32'd10, 4'd5, 1'b1);
        drain(100);
        chk("t6_err_after_op", 64'(err_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
